// File: rtl/pep_ks_common_param_pkg.sv
// Shared key-switch parameters plus the buffered block layout used by the LWE output stage.
package pep_ks_common_param_pkg;

  localparam int MOD_KSK_W       = 16;
  localparam int PID_W           = 5;
  localparam int LBX             = 3;
  localparam int LWE_K_P1        = 5;
  localparam int KS_BLOCK_COL_NB = (LWE_K_P1 + LBX - 1) / LBX;
  localparam int KS_BLOCK_COL_W  = (KS_BLOCK_COL_NB > 1) ? $clog2(KS_BLOCK_COL_NB) : 1;
  localparam int KS_COL_W        = (KS_BLOCK_COL_NB * LBX > 1) ? $clog2(KS_BLOCK_COL_NB * LBX) : 1;
  localparam int KS_X_W          = (LBX > 1) ? $clog2(LBX) : 1;
  localparam int OUT_FIFO_DEPTH  = 4;

  // The final column block only carries the columns that remain after the full blocks.
  localparam int KS_LAST_BLK_COL_NB = LWE_K_P1 - (KS_BLOCK_COL_NB - 1) * LBX;

  typedef struct packed {
    logic [LBX-1:0][MOD_KSK_W-1:0] data;
    logic [PID_W-1:0]              pid;
    logic [KS_BLOCK_COL_W-1:0]     col_blk;
  } lwe_blk_t;

  typedef enum logic {
    SER_IDLE = 1'b0,
    SER_RUN  = 1'b1
  } ser_state_e;

  function automatic logic [KS_X_W-1:0] blk_last_x(input logic [KS_BLOCK_COL_W-1:0] col);
    return (int'(col) == KS_BLOCK_COL_NB - 1) ? KS_X_W'(KS_LAST_BLK_COL_NB - 1)
                                               : KS_X_W'(LBX - 1);
  endfunction

  function automatic logic [KS_COL_W-1:0] blk_base_idx(input logic [KS_BLOCK_COL_W-1:0] col);
    return KS_COL_W'(int'(col) * LBX);
  endfunction

endpackage

// File: rtl/pep_ks_out_fifo.sv
// Generic DEPTH x WIDTH FIFO with registered write-ready; pointers wrap at any DEPTH.
module pep_ks_out_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             s_rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_rdy,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    cnt_nxt = cnt;
    if (wr_en && !rd_en)      cnt_nxt = cnt + 1'b1;
    else if (!wr_en && rd_en) cnt_nxt = cnt - 1'b1;
  end

  // wr_rdy is looked ahead from cnt_nxt so it equals !full of the registered count.
  always_ff @(posedge clk) begin
    if (s_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      wr_rdy <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= ptr_inc(wr_ptr);
      if (rd_en) rd_ptr <= ptr_inc(rd_ptr);
      cnt    <= cnt_nxt;
      wr_rdy <= (cnt_nxt != CNT_W'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];
  assign full    = (cnt == CNT_W'(DEPTH));
  assign empty   = (cnt == '0);

endmodule

// File: rtl/pep_ks_lwe_out_buf.sv
// KS output stage: buffers LBX-wide column blocks and serializes valid coefficients one per cycle.
module pep_ks_lwe_out_buf
  import pep_ks_common_param_pkg::*;
#(
  parameter int DATA_W     = MOD_KSK_W,
  parameter int FIFO_DEPTH = OUT_FIFO_DEPTH
) (
  input  logic                      clk,
  input  logic                      s_rst,
  input  logic                      in_vld,
  output logic                      in_rdy,
  input  logic [LBX*DATA_W-1:0]     in_data,
  input  logic [PID_W-1:0]          in_pid,
  input  logic [KS_BLOCK_COL_W-1:0] in_col_blk,
  output logic                      out_vld,
  input  logic                      out_rdy,
  output logic [DATA_W-1:0]         out_data,
  output logic [PID_W-1:0]          out_pid,
  output logic [KS_COL_W-1:0]       out_idx,
  output logic                      out_last,
  output logic                      fifo_empty
);

  localparam int BLK_W = $bits(lwe_blk_t);
  localparam logic [KS_COL_W-1:0] LAST_IDX = KS_COL_W'(LWE_K_P1 - 1);

  lwe_blk_t         blk_in;
  lwe_blk_t         head;
  logic [BLK_W-1:0] fifo_rd;
  logic             push;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty_w;

  assign blk_in.data    = in_data;
  assign blk_in.pid     = in_pid;
  assign blk_in.col_blk = in_col_blk;
  assign push           = in_vld && in_rdy;
  assign head           = fifo_rd;

  pep_ks_out_fifo #(
    .WIDTH (BLK_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .s_rst   (s_rst),
    .wr_en   (push),
    .wr_data (blk_in),
    .wr_rdy  (in_rdy),
    .rd_en   (pop),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty_w)
  );

  ser_state_e                state_q;
  ser_state_e                state_nxt;
  logic                      load;
  logic                      adv;
  logic                      x_last;
  logic [LBX*DATA_W-1:0]     sh_p1;
  logic [PID_W-1:0]          pid_p1;
  logic [KS_COL_W-1:0]       idx_p1;
  logic [KS_COL_W-1:0]       idx_inc;
  logic                      last_p1;
  logic [KS_X_W-1:0]         x_p1;
  logic [KS_X_W-1:0]         lastx_p1;

  assign x_last  = (x_p1 == lastx_p1);
  assign idx_inc = idx_p1 + 1'b1;

  always_ff @(posedge clk) begin
    if (s_rst) state_q <= SER_IDLE;
    else       state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      SER_IDLE: if (!fifo_empty_w) state_nxt = SER_RUN;
      SER_RUN:  if (out_rdy && x_last && fifo_empty_w) state_nxt = SER_IDLE;
      default:  state_nxt = SER_IDLE;
    endcase
  end

  // On the last column of a block the next head is loaded in the same cycle: no bubble.
  always_comb begin
    load = 1'b0;
    adv  = 1'b0;
    case (state_q)
      SER_IDLE: load = !fifo_empty_w;
      SER_RUN: begin
        if (out_rdy) begin
          if (x_last) load = !fifo_empty_w;
          else        adv  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign pop = load;

  // Output stage: shift register presents column x in its low DATA_W bits.
  always_ff @(posedge clk) begin
    if (s_rst) begin
      sh_p1    <= '0;
      pid_p1   <= '0;
      idx_p1   <= '0;
      last_p1  <= 1'b0;
      x_p1     <= '0;
      lastx_p1 <= '0;
    end else if (load) begin
      sh_p1    <= head.data;
      pid_p1   <= head.pid;
      idx_p1   <= blk_base_idx(head.col_blk);
      last_p1  <= (blk_base_idx(head.col_blk) == LAST_IDX);
      x_p1     <= '0;
      lastx_p1 <= blk_last_x(head.col_blk);
    end else if (adv) begin
      sh_p1    <= sh_p1 >> DATA_W;
      idx_p1   <= idx_inc;
      last_p1  <= (idx_inc == LAST_IDX);
      x_p1     <= x_p1 + 1'b1;
    end
  end

  assign out_vld    = (state_q == SER_RUN);
  assign out_data   = sh_p1[DATA_W-1:0];
  assign out_pid    = pid_p1;
  assign out_idx    = idx_p1;
  assign out_last   = last_p1;
  assign fifo_empty = fifo_empty_w && (state_q == SER_IDLE);

  col_blk_legal_a: assert property (@(posedge clk) disable iff (s_rst)
    push |-> (int'(in_col_blk) < KS_BLOCK_COL_NB))
    else $error("in_col_blk out of range: %0d", in_col_blk);

  no_overflow_a: assert property (@(posedge clk) disable iff (s_rst) !(push && fifo_full))
    else $error("push into full output FIFO");

endmodule

// File: tb/tb_pep_ks_lwe_out_buf.sv
// Bench for pep_ks_lwe_out_buf: queue-based coefficient model checked every valid output cycle.
module tb_pep_ks_lwe_out_buf;
  import pep_ks_common_param_pkg::*;

  localparam int DATA_W     = MOD_KSK_W;
  localparam int FIFO_DEPTH = OUT_FIFO_DEPTH;

  logic                      clk = 1'b0;
  logic                      s_rst = 1'b1;
  logic                      in_vld = 1'b0;
  logic                      in_rdy;
  logic [LBX*DATA_W-1:0]     in_data = '0;
  logic [PID_W-1:0]          in_pid = '0;
  logic [KS_BLOCK_COL_W-1:0] in_col_blk = '0;
  logic                      out_vld;
  logic                      out_rdy = 1'b0;
  logic [DATA_W-1:0]         out_data;
  logic [PID_W-1:0]          out_pid;
  logic [KS_COL_W-1:0]       out_idx;
  logic                      out_last;
  logic                      fifo_empty;

  always #5 clk = ~clk;

  pep_ks_lwe_out_buf #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .s_rst(s_rst),
    .in_vld(in_vld), .in_rdy(in_rdy), .in_data(in_data), .in_pid(in_pid), .in_col_blk(in_col_blk),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data), .out_pid(out_pid),
    .out_idx(out_idx), .out_last(out_last), .fifo_empty(fifo_empty)
  );

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [PID_W-1:0]  pid;
    int                idx;
    bit                last;
  } coef_t;

  coef_t exp_q[$];
  coef_t got_q[$];
  int    n_cmp = 0;
  int    n_err = 0;
  int    cyc = 0;
  int    vld_cnt = 0;
  int    first_cyc = -1;
  int    last_cyc = -1;
  bit    bp_done = 1'b0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Expected coefficients of one accepted block: padding columns past LWE_K_P1 are dropped.
  function automatic void model_push(input logic [LBX*DATA_W-1:0] d, input logic [PID_W-1:0] p,
                                     input int col);
    coef_t c;
    int ncol;
    ncol = (col == KS_BLOCK_COL_NB - 1) ? (LWE_K_P1 - col * LBX) : LBX;
    for (int x = 0; x < ncol; x++) begin
      c.data = d[x*DATA_W +: DATA_W];
      c.pid  = p;
      c.idx  = col * LBX + x;
      c.last = (c.idx == LWE_K_P1 - 1);
      exp_q.push_back(c);
    end
  endfunction

  always @(negedge clk) begin
    if (out_vld === 1'b1) begin
      vld_cnt++;
      if (first_cyc < 0) first_cyc = cyc;
      last_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("unexpected_out_vld", 1, 0);
      end else begin
        check("out_data", out_data, exp_q[0].data);
        check("out_pid", out_pid, exp_q[0].pid);
        check("out_idx", out_idx, exp_q[0].idx);
        check("out_last", out_last, exp_q[0].last);
      end
    end
    if (s_rst === 1'b1) begin
      exp_q.delete();
    end else begin
      if (out_vld === 1'b1 && out_rdy) begin
        got_q.push_back('{data: out_data, pid: out_pid, idx: int'(out_idx), last: out_last});
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      if (in_vld && in_rdy === 1'b1) model_push(in_data, in_pid, int'(in_col_blk));
    end
  end

  function automatic logic [LBX*DATA_W-1:0] pack3(input logic [DATA_W-1:0] a, b, c);
    return {c, b, a};
  endfunction

  task automatic send(input logic [LBX*DATA_W-1:0] d, input int pid, input int col);
    bit ok;
    int n;
    n = 0;
    in_vld = 1'b1; in_data = d; in_pid = PID_W'(pid); in_col_blk = KS_BLOCK_COL_W'(col);
    do begin
      @(negedge clk);
      ok = (in_rdy === 1'b1);
      @(posedge clk); #1;
      n++;
    end while (!ok && n < 300);
    if (!ok) check("send_timeout", 0, 1);
    in_vld = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (n < 500 && !(exp_q.size() == 0 && fifo_empty === 1'b1 && out_vld === 1'b0)) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_rdy", in_rdy, 0);
    check("rst_out_vld", out_vld, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_pid", out_pid, 0);
    check("rst_out_idx", out_idx, 0);
    check("rst_out_last", out_last, 0);
    check("rst_fifo_empty", fifo_empty, 1);
    s_rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_in_rdy", in_rdy, 1);

    // Single PBS with latency pins
    out_rdy = 1'b1;
    got_q.delete();
    send(pack3(10, 11, 12), 7, 0);
    check("lat_t1_vld", out_vld, 0);
    @(posedge clk); #1;
    check("lat_t2_vld", out_vld, 1);
    check("lat_t2_data", out_data, 10);
    check("lat_t2_idx", out_idx, 0);
    send(pack3(13, 14, 99), 7, 1);
    drain("single_drain");
    check("single_cnt", got_q.size(), 5);
    for (int i = 0; i < 5 && i < got_q.size(); i++) begin
      check("single_data", got_q[i].data, 10 + i);
      check("single_idx", got_q[i].idx, i);
      check("single_last", got_q[i].last, (i == 4));
      check("single_pid", got_q[i].pid, 7);
    end

    // Back-to-back: 4 PBS, no bubble
    got_q.delete(); vld_cnt = 0; first_cyc = -1; last_cyc = -1;
    for (int p = 1; p <= 4; p++) begin
      send(pack3(DATA_W'($urandom), DATA_W'($urandom), DATA_W'($urandom)), p, 0);
      send(pack3(DATA_W'($urandom), DATA_W'($urandom), DATA_W'($urandom)), p, 1);
    end
    drain("b2b_drain");
    check("b2b_cnt", got_q.size(), 20);
    check("b2b_vld_cycles", vld_cnt, 20);
    check("b2b_span", last_cyc - first_cyc + 1, 20);
    if (got_q.size() == 20) begin
      check("b2b_pid_first", got_q[0].pid, 1);
      check("b2b_pid_last", got_q[19].pid, 4);
      check("b2b_last_flag", got_q[19].last, 1);
    end

    // Full: the serializer holds one block, so the buffer fills after FIFO_DEPTH+1 pushes
    out_rdy = 1'b0;
    got_q.delete();
    send(pack3(1, 2, 3), 5, 0);
    send(pack3(4, 5, 99), 5, 1);
    send(pack3(6, 7, 8), 6, 0);
    send(pack3(9, 10, 98), 6, 1);
    send(pack3(11, 12, 13), 8, 0);
    check("full_in_rdy", in_rdy, 0);
    in_vld = 1'b1; in_data = pack3(14, 15, 97); in_pid = PID_W'(8); in_col_blk = KS_BLOCK_COL_W'(1);
    repeat (4) begin
      @(negedge clk);
      check("full_hold_rdy", in_rdy, 0);
    end
    @(posedge clk); #1;
    out_rdy = 1'b1;
    send(pack3(14, 15, 97), 8, 1);
    drain("full_drain");
    check("full_cnt", got_q.size(), 15);
    if (got_q.size() == 15) begin
      check("full_first", got_q[0].data, 1);
      check("full_last_data", got_q[14].data, 15);
      check("full_last_idx", got_q[14].idx, 4);
    end

    // Simultaneous push and pop at occupancy FIFO_DEPTH-1
    out_rdy = 1'b0;
    got_q.delete();
    send(pack3(31, 32, 33), 2, 0);
    send(pack3(34, 35, 0), 2, 1);
    send(pack3(36, 37, 38), 3, 0);
    send(pack3(39, 40, 0), 3, 1);
    check("pp_rdy_pre", in_rdy, 1);
    out_rdy = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    send(pack3(41, 42, 43), 4, 0);
    check("pp_rdy_post", in_rdy, 1);
    drain("pp_drain");
    check("pp_cnt", got_q.size(), 13);
    if (got_q.size() == 13) check("pp_tail", got_q[12].data, 43);

    // Random backpressure at 30% ready
    got_q.delete();
    bp_done = 1'b0;
    fork
      begin
        for (int b = 0; b < 12; b++) begin
          if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
          send(pack3(DATA_W'($urandom), DATA_W'($urandom), DATA_W'($urandom)),
               $urandom_range(0, 31), $urandom_range(0, KS_BLOCK_COL_NB - 1));
        end
        bp_done = 1'b1;
      end
      begin
        while (!bp_done) begin
          @(posedge clk); #1;
          out_rdy = ($urandom_range(0, 99) < 30);
        end
      end
    join
    repeat (150) begin @(posedge clk); #1; out_rdy = ($urandom_range(0, 99) < 30); end
    out_rdy = 1'b1;
    drain("bp_drain");

    // Reset mid-block
    out_rdy = 1'b0;
    got_q.delete();
    send(pack3(51, 52, 53), 1, 0);
    send(pack3(54, 55, 0), 1, 1);
    check("mid_pre_vld", out_vld, 1);
    out_rdy = 1'b1;
    @(posedge clk); #1;
    out_rdy = 1'b0;
    s_rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_vld", out_vld, 0);
    check("mid_rst_empty", fifo_empty, 1);
    check("mid_rst_in_rdy", in_rdy, 0);
    check("mid_rst_idx", out_idx, 0);
    s_rst = 1'b0;
    @(posedge clk); #1;
    got_q.delete();
    out_rdy = 1'b1;
    send(pack3(61, 62, 63), 9, 0);
    drain("mid_drain");
    check("mid_cnt", got_q.size(), 3);
    if (got_q.size() == 3) begin
      check("mid_first_idx", got_q[0].idx, 0);
      check("mid_first_data", got_q[0].data, 61);
      check("mid_first_pid", got_q[0].pid, 9);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
